// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, NOP encoding, loader state encoding
// and the opcode constants used to build instruction words.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // I-type word: opcode | rs | rt | imm16
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_ram.sv
// DEPTH x DATA_W instruction array: one write port, one registered read port.
// No reset on the array or the read register so it maps onto block RAM.
module instr_ram #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
        // rd_en low holds the last word, which gives the IF stage its stall behaviour
        if (rd_en) begin
            rd_data_reg <= mem_reg[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/instr_load_mem.sv
// Instruction memory with word-serial loader (IDLE -> LOAD -> RUN) and 1-cycle fetch port.
// Define INSTR_MEM_BOUNDS_NOP_EN to return NOP for fetches at or beyond the loaded image.
module instr_load_mem #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              LoadInstructions,
    input  logic [DATA_W-1:0] Instruction,
    input  logic              fetch_en,
    input  logic [31:0]       pc,
    output logic [DATA_W-1:0] instr_out,
    output logic              ready,
    output logic [ADDR_W:0]   load_count,
    output logic              load_done,
    output logic              overflow,
    output logic              misalign
);
    import cpu_pkg::*;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_CNT   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_reg, state_next;
    logic [ADDR_W:0]   wr_ptr_reg, wr_ptr_next;
    logic              overflow_reg, overflow_next;
    logic              load_done_reg, load_done_next;
    logic              misalign_reg, misalign_next;
    logic              nop_reg, nop_next;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_idx;
    logic              in_bounds;
    logic [DATA_W-1:0] rd_data;
    logic              unused_pc;

    assign rd_idx    = pc[ADDR_W+1:2];
    assign unused_pc = ^pc[31:ADDR_W+2];

`ifdef INSTR_MEM_BOUNDS_NOP_EN
    assign in_bounds = ({1'b0, rd_idx} < wr_ptr_reg);
`else
    assign in_bounds = 1'b1;
`endif

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (LoadInstructions)  state_next = LOAD;
            LOAD:    if (!LoadInstructions) state_next = RUN;
            RUN:     if (LoadInstructions)  state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    // A load strobe always wins over a fetch in the same cycle; the write pointer
    // doubles as the loaded-word count and saturates at DEPTH.
    always_comb begin
        wr_en          = 1'b0;
        wr_addr        = '0;
        rd_en          = 1'b0;
        wr_ptr_next    = wr_ptr_reg;
        overflow_next  = overflow_reg;
        load_done_next = 1'b0;
        misalign_next  = misalign_reg;
        nop_next       = nop_reg;
        case (state_reg)
            IDLE, RUN: begin
                if (LoadInstructions) begin
                    wr_en         = 1'b1;
                    wr_addr       = '0;
                    wr_ptr_next   = ONE_CNT;
                    overflow_next = 1'b0;
                    nop_next      = 1'b1;
                end else if ((state_reg == RUN) && fetch_en) begin
                    rd_en         = 1'b1;
                    misalign_next = (pc[1:0] != 2'b00);
                    nop_next      = (pc[1:0] != 2'b00) || !in_bounds;
                end
            end
            LOAD: begin
                nop_next = 1'b1;
                if (LoadInstructions) begin
                    if (wr_ptr_reg < DEPTH_CNT) begin
                        wr_en       = 1'b1;
                        wr_addr     = wr_ptr_reg[ADDR_W-1:0];
                        wr_ptr_next = wr_ptr_reg + 1'b1;
                    end else begin
                        overflow_next = 1'b1;
                    end
                end else begin
                    load_done_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_reg    <= '0;
            overflow_reg  <= 1'b0;
            load_done_reg <= 1'b0;
            misalign_reg  <= 1'b0;
            nop_reg       <= 1'b1;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            overflow_reg  <= overflow_next;
            load_done_reg <= load_done_next;
            misalign_reg  <= misalign_next;
            nop_reg       <= nop_next;
        end
    end

    instr_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (Instruction),
        .rd_en   (rd_en),
        .rd_addr (rd_idx),
        .rd_data (rd_data)
    );

    // The RAM read register has no reset; nop_reg masks it until a real fetch lands.
    assign instr_out  = nop_reg ? DATA_W'(NOP) : rd_data;
    assign ready      = (state_reg == RUN);
    assign load_count = wr_ptr_reg;
    assign load_done  = load_done_reg;
    assign overflow   = overflow_reg;
    assign misalign   = misalign_reg;

endmodule

// File: tb/tb_instr_load_mem.sv
// Directed bench for instr_load_mem: load, fetch, misalign/stall, overflow, reload, async reset.
// Expected stale-word values switch with INSTR_MEM_BOUNDS_NOP_EN.
module tb_instr_load_mem;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_instr;
    logic [31:0] instruction;
    logic        fetch_en;
    logic [31:0] pc;
    logic [31:0] instr_out;
    logic        ready;
    logic [6:0]  load_count;
    logic        load_done;
    logic        overflow;
    logic        misalign;

    int total = 0;
    int bad   = 0;

`ifdef INSTR_MEM_BOUNDS_NOP_EN
    localparam logic [31:0] EXP_PC20    = 32'h0;
    localparam logic [31:0] EXP_RL_PC8  = 32'h0;
    localparam logic [31:0] EXP_RL_PC252 = 32'h0;
    localparam logic [31:0] EXP_AB_PC4  = 32'h0;
    localparam logic [31:0] EXP_AB_PC8  = 32'h0;
`else
    localparam logic [31:0] EXP_PC20    = 32'hxxxx_xxxx;
    localparam logic [31:0] EXP_RL_PC8  = 32'h0000_0003;
    localparam logic [31:0] EXP_RL_PC252 = 32'h0000_0040;
    localparam logic [31:0] EXP_AB_PC4  = 32'h0000_0022;
    localparam logic [31:0] EXP_AB_PC8  = 32'h0000_0033;
`endif

    always #5 clk = ~clk;

    instr_load_mem dut (
        .clk              (clk),
        .Reset            (reset_n),
        .LoadInstructions (load_instr),
        .Instruction      (instruction),
        .fetch_en         (fetch_en),
        .pc               (pc),
        .instr_out        (instr_out),
        .ready            (ready),
        .load_count       (load_count),
        .load_done        (load_done),
        .overflow         (overflow),
        .misalign         (misalign)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; load_instr = 1'b0; instruction = '0; fetch_en = 1'b0; pc = '0;
        #12;
        total++; if (instr_out !== 32'h0) begin bad++; $display("FAIL reset_instr_out got=%h exp=%h", instr_out, 32'h0); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
        total++; if (load_count !== 7'd0) begin bad++; $display("FAIL reset_load_count got=%0d exp=0", load_count); end
        total++; if ({load_done, overflow, misalign} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {load_done, overflow, misalign}); end
        tick();
        reset_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_load();
        logic [15:0] imm [5] = '{16'h01A7, 16'h005C, 16'h000D, 16'h0092, 16'h0005};
        for (int i = 0; i < 5; i++) begin
            load_instr = 1'b1;
            instruction = enc_i(OP_ADDI, 5'd0, 5'(i + 1), imm[i]);
            tick();
            $display("load word %0d = %h", i, instruction);
            total++; if (load_count !== 7'(i + 1)) begin bad++; $display("FAIL load_count_%0d got=%0d exp=%0d", i, load_count, i + 1); end
            total++; if (ready !== 1'b0) begin bad++; $display("FAIL load_ready_%0d got=%b exp=0", i, ready); end
        end
        load_instr = 1'b0;
        tick();
        total++; if (load_done !== 1'b1) begin bad++; $display("FAIL load_done_pulse got=%b exp=1", load_done); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL load_ready_run got=%b exp=1", ready); end
        total++; if (load_count !== 7'd5) begin bad++; $display("FAIL load_count_final got=%0d exp=5", load_count); end
        tick();
        total++; if (load_done !== 1'b0) begin bad++; $display("FAIL load_done_once got=%b exp=0", load_done); end
    endtask

    task automatic test_fetch();
        logic [31:0] img [5] = '{32'h200101A7, 32'h2002005C, 32'h2003000D, 32'h20040092, 32'h20050005};
        fetch_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pc = 32'(4 * i);
            tick();
            $display("fetch pc=%h instr=%h", pc, instr_out);
            total++; if (instr_out !== img[i]) begin bad++; $display("FAIL fetch_pc%0d got=%h exp=%h", 4 * i, instr_out, img[i]); end
            total++; if (misalign !== 1'b0) begin bad++; $display("FAIL fetch_misalign_pc%0d got=%b exp=0", 4 * i, misalign); end
        end
        pc = 32'd20;
        tick();
        $display("fetch pc=%h instr=%h", pc, instr_out);
`ifdef INSTR_MEM_BOUNDS_NOP_EN
        total++; if (instr_out !== EXP_PC20) begin bad++; $display("FAIL fetch_pc20_bounds got=%h exp=%h", instr_out, EXP_PC20); end
`endif
        pc = 32'h0000_0100;
        tick();
        $display("fetch pc=%h instr=%h", pc, instr_out);
        total++; if (instr_out !== 32'h200101A7) begin bad++; $display("FAIL fetch_high_pc_bits got=%h exp=200101a7", instr_out); end
        total++; if (load_count !== 7'd5) begin bad++; $display("FAIL fetch_count_stable got=%0d exp=5", load_count); end
    endtask

    task automatic test_misalign_stall();
        fetch_en = 1'b1; pc = 32'd8;
        tick();
        total++; if (instr_out !== 32'h2003000D) begin bad++; $display("FAIL stall_pre got=%h exp=2003000d", instr_out); end
        fetch_en = 1'b0; pc = 32'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (instr_out !== 32'h2003000D) begin bad++; $display("FAIL stall_hold_%0d got=%h exp=2003000d", i, instr_out); end
        end
        fetch_en = 1'b1; pc = 32'd6;
        tick();
        $display("fetch pc=%h instr=%h misalign=%b", pc, instr_out, misalign);
        total++; if (misalign !== 1'b1) begin bad++; $display("FAIL misalign_flag got=%b exp=1", misalign); end
        total++; if (instr_out !== 32'h0) begin bad++; $display("FAIL misalign_nop got=%h exp=0", instr_out); end
        fetch_en = 1'b0; pc = 32'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (instr_out !== 32'h0) begin bad++; $display("FAIL misalign_hold_%0d got=%h exp=0", i, instr_out); end
            total++; if (misalign !== 1'b1) begin bad++; $display("FAIL misalign_sticky_%0d got=%b exp=1", i, misalign); end
        end
        fetch_en = 1'b1;
        tick();
        total++; if (instr_out !== 32'h2002005C) begin bad++; $display("FAIL realign_instr got=%h exp=2002005c", instr_out); end
        total++; if (misalign !== 1'b0) begin bad++; $display("FAIL realign_flag got=%b exp=0", misalign); end
    endtask

    task automatic test_overflow();
        fetch_en = 1'b1; pc = 32'd4;
        for (int i = 0; i < 67; i++) begin
            int ec;
            ec = (i + 1 > 64) ? 64 : i + 1;
            load_instr = 1'b1;
            instruction = 32'(i + 1);
            tick();
            total++; if (load_count !== 7'(ec)) begin bad++; $display("FAIL ovf_count_%0d got=%0d exp=%0d", i, load_count, ec); end
            total++; if (overflow !== (i >= 64)) begin bad++; $display("FAIL ovf_flag_%0d got=%b exp=%b", i, overflow, i >= 64); end
            total++; if ((instr_out !== 32'h0) || (ready !== 1'b0)) begin bad++; $display("FAIL ovf_bubble_%0d instr=%h ready=%b exp=0/0", i, instr_out, ready); end
        end
        $display("overflow load: 67 words sent, count=%0d overflow=%b", load_count, overflow);
        load_instr = 1'b0;
        tick();
        total++; if ({load_done, ready, overflow} !== 3'b111) begin bad++; $display("FAIL ovf_end got=%b exp=111", {load_done, ready, overflow}); end
        pc = 32'd252;
        tick();
        $display("fetch pc=%h instr=%h", pc, instr_out);
        total++; if (instr_out !== 32'h40) begin bad++; $display("FAIL ovf_last_word got=%h exp=00000040", instr_out); end
        pc = 32'd0;
        tick();
        $display("fetch pc=%h instr=%h", pc, instr_out);
        total++; if (instr_out !== 32'h1) begin bad++; $display("FAIL ovf_no_wrap got=%h exp=00000001", instr_out); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        fetch_en = 1'b0;
    endtask

    task automatic test_reload();
        logic [31:0] pcs [4] = '{32'd4, 32'd0, 32'd8, 32'd252};
        logic [31:0] exps [4];
        exps = '{32'hBBBB0000, 32'hAAAA0000, EXP_RL_PC8, EXP_RL_PC252};
        load_instr = 1'b1; instruction = 32'hAAAA0000;
        tick();
        total++; if ({load_count, overflow, ready} !== {7'd1, 1'b0, 1'b0}) begin bad++; $display("FAIL reload_first count=%0d ovf=%b ready=%b exp=1/0/0", load_count, overflow, ready); end
        instruction = 32'hBBBB0000;
        tick();
        total++; if (load_count !== 7'd2) begin bad++; $display("FAIL reload_count got=%0d exp=2", load_count); end
        load_instr = 1'b0;
        tick();
        total++; if ({load_done, ready, overflow} !== 3'b110) begin bad++; $display("FAIL reload_end got=%b exp=110", {load_done, ready, overflow}); end
        fetch_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc = pcs[i];
            tick();
            $display("fetch pc=%h instr=%h", pc, instr_out);
            total++; if (instr_out !== exps[i]) begin bad++; $display("FAIL reload_pc%0d got=%h exp=%h", pcs[i], instr_out, exps[i]); end
        end
        fetch_en = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [31:0] words [3] = '{32'h11, 32'h22, 32'h33};
        for (int i = 0; i < 3; i++) begin
            load_instr = 1'b1; instruction = words[i];
            tick();
        end
        total++; if (load_count !== 7'd3) begin bad++; $display("FAIL abort_pre_count got=%0d exp=3", load_count); end
        #3;
        reset_n = 1'b0;
        #1;
        total++; if (load_count !== 7'd0) begin bad++; $display("FAIL abort_async_count got=%0d exp=0", load_count); end
        total++; if ({ready, load_done, overflow, instr_out} !== 35'h0) begin bad++; $display("FAIL abort_async_outs ready=%b done=%b ovf=%b instr=%h exp=0", ready, load_done, overflow, instr_out); end
        load_instr = 1'b0;
        tick();
        reset_n = 1'b1;
        $display("mid-load reset applied and released");
        load_instr = 1'b1; instruction = 32'h44;
        tick();
        total++; if ({load_count, ready} !== {7'd1, 1'b0}) begin bad++; $display("FAIL abort_reload count=%0d ready=%b exp=1/0", load_count, ready); end
        load_instr = 1'b0;
        tick();
        total++; if ({load_done, ready} !== 2'b11) begin bad++; $display("FAIL abort_run got=%b exp=11", {load_done, ready}); end
        fetch_en = 1'b1; pc = 32'd0;
        tick();
        total++; if (instr_out !== 32'h44) begin bad++; $display("FAIL abort_pc0 got=%h exp=00000044", instr_out); end
        pc = 32'd4;
        tick();
        $display("fetch pc=%h instr=%h", pc, instr_out);
        total++; if (instr_out !== EXP_AB_PC4) begin bad++; $display("FAIL abort_pc4 got=%h exp=%h", instr_out, EXP_AB_PC4); end
        pc = 32'd8;
        tick();
        $display("fetch pc=%h instr=%h", pc, instr_out);
        total++; if (instr_out !== EXP_AB_PC8) begin bad++; $display("FAIL abort_pc8 got=%h exp=%h", instr_out, EXP_AB_PC8); end
        fetch_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_fetch();
        test_misalign_stall();
        test_overflow();
        test_reload();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
